// File: rtl/repsub_divider.sv
// Sequential unsigned divider by repeated subtraction: a start pulse loads the
// operands, the FSM subtracts the divisor until R < D, then strobes done.
module repsub_divider #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_by_zero_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_SUB   = 3'd2,
      S_DONE  = 3'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;

   // Subtract unit and comparator shared by the controller.
   logic [WIDTH-1:0] diff;
   logic             r_ge_d;
   assign diff   = r_q - d_q;
   assign r_ge_d = (r_q >= d_q);

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      d_d     = d_q;
      q_d     = q_q;
      dbz_d   = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               r_d     = dividend_i;
               d_d     = divisor_i;
               q_d     = '0;
               dbz_d   = 1'b0;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (d_q == '0) begin
               q_d     = '1;
               dbz_d   = 1'b1;
               state_d = S_DONE;
            end else if (r_ge_d) begin
               state_d = S_SUB;
            end else begin
               state_d = S_DONE;
            end
         end
         S_SUB: begin
            r_d     = diff;
            q_d     = q_q + 1'b1;
            state_d = S_CHECK;
         end
         S_DONE: state_d = S_IDLE;
         default: begin
            // Illegal encoding recovers exactly like a reset.
            state_d = S_IDLE;
            r_d     = '0;
            d_d     = '0;
            q_d     = '0;
            dbz_d   = 1'b0;
         end
      endcase
      busy_d = (state_d == S_CHECK) || (state_d == S_SUB) || (state_d == S_DONE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         d_q     <= '0;
         q_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         d_q     <= d_d;
         q_q     <= q_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign div_by_zero_o = dbz_q;
   assign quotient_o    = q_q;
   assign remainder_o   = r_q;

endmodule

// File: tb/tb_repsub_divider.sv
// Directed and random checks of repsub_divider: results, latency, busy/done.
module tb_repsub_divider;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] dividend = '0;
   logic [15:0] divisor = '0;
   logic        busy, done, dbz;
   logic [15:0] quotient, remainder;

   int errors = 0;
   int checks = 0;

   repsub_divider #(.WIDTH(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start),
      .dividend_i   (dividend),
      .divisor_i    (divisor),
      .busy_o       (busy),
      .done_o       (done),
      .div_by_zero_o(dbz),
      .quotient_o   (quotient),
      .remainder_o  (remainder)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Called right after edge A (at the posedge). Counts edges including A
   // until done is seen, checks busy every cycle and done width afterwards.
   task automatic wait_done(input bit keep, input logic [15:0] nn, input logic [15:0] nd,
                            output int lat);
      lat = 1;
      @(negedge clk);
      if (keep) begin
         dividend = nn;
         divisor  = nd;
      end else begin
         start = 1'b0;
      end
      while (!done && lat < 5000) begin
         chk("busy_run", busy, 1);
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      if (!done) chk("timeout", 0, 1);
      else chk("busy_at_done", busy, 1);
      @(posedge clk);
      @(negedge clk);
      chk("done_width", done, 0);
      chk("busy_idle", busy, 0);
   endtask

   task automatic run_op(input string tag, input logic [15:0] n, input logic [15:0] d,
                         input logic [15:0] eq, input logic [15:0] er, input bit edbz,
                         input int elat);
      int lat;
      @(negedge clk);
      dividend = n;
      divisor  = d;
      start    = 1'b1;
      @(posedge clk);
      wait_done(1'b0, 16'd0, 16'd0, lat);
      chk({tag, "_q"}, quotient, eq);
      chk({tag, "_r"}, remainder, er);
      chk({tag, "_dbz"}, dbz, edbz);
      chk({tag, "_lat"}, lat, elat);
   endtask

   initial begin
      int lat;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dbz", dbz, 0);
      chk("rst_q", quotient, 0);
      chk("rst_r", remainder, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 30);
      run_op("d5_9", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 2);
      run_op("d9_9", 16'd9, 16'd9, 16'd1, 16'd0, 1'b0, 4);
      run_op("d0_3", 16'd0, 16'd3, 16'd0, 16'd0, 1'b0, 2);
      run_op("d1234_0", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 2);
      chk("dbz_hold", dbz, 1);
      run_op("d10_3", 16'd10, 16'd3, 16'd3, 16'd1, 1'b0, 8);

      // start held high; operands change while busy and must not matter.
      @(negedge clk);
      dividend = 16'd1000;
      divisor  = 16'd1;
      start    = 1'b1;
      @(posedge clk);
      wait_done(1'b1, 16'd20, 16'd3, lat);
      chk("hold1_lat", lat, 2002);
      chk("hold1_q", quotient, 1000);
      chk("hold1_r", remainder, 0);
      @(posedge clk);
      wait_done(1'b0, 16'd0, 16'd0, lat);
      chk("hold2_lat", lat, 14);
      chk("hold2_q", quotient, 6);
      chk("hold2_r", remainder, 2);

      // Asynchronous reset in the middle of 500/2.
      @(negedge clk);
      dividend = 16'd500;
      divisor  = 16'd2;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         chk("mid_no_done", done, 0);
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_q", quotient, 0);
      chk("arst_r", remainder, 0);
      chk("arst_dbz", dbz, 0);
      @(negedge clk);
      chk("arst_done2", done, 0);
      rst_n = 1'b1;
      run_op("d17_4", 16'd17, 16'd4, 16'd4, 16'd1, 1'b0, 10);

      for (int k = 0; k < 1000; k++) begin
         logic [15:0] n, d, eq, er;
         n  = 16'($urandom_range(0, 300));
         d  = 16'($urandom_range(1, 300));
         eq = n / d;
         er = n % d;
         run_op("rnd", n, d, eq, er, 1'b0, 2 * int'(eq) + 2);
         chk("rnd_inv", 32'(quotient) * 32'(d) + 32'(remainder), 32'(n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/repsub_divider.md
# repsub_divider

Sequential 16-bit unsigned divider using repeated subtraction. It is the inverse of the team's repeated-addition multiplier and uses the same datapath/controller split: working registers, a subtract unit, a comparator and a small FSM. A start pulse loads the operands. The block subtracts the divisor until the remainder is smaller than it, then raises a one-cycle done strobe with quotient and remainder.

## Interface
- WIDTH, 16, operand and result width (all arithmetic unsigned)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  numerator; sampled on the accepting edge only
- divisor  input  WIDTH  denominator; sampled on the accepting edge only
- busy  output  1  high from the cycle after acceptance until DONE is left
- done  output  1  one-cycle strobe; results valid
- div_by_zero  output  1  set when divisor was 0; held until next acceptance
- quotient  output  WIDTH  quotient register Q
- remainder  output  WIDTH  remainder register R

## Operation
- Registers: R (remainder), D (divisor), Q (quotient), 3-bit state. All registered outputs.
- Reset (rst_n=0, asynchronous): state=IDLE; R, D, Q=0; busy=0, done=0, div_by_zero=0. Reset mid-operation aborts with no done strobe.
- **IDLE**: busy=0.
  - start=1 at a clock edge: R<=dividend, D<=divisor, Q<=0, div_by_zero<=0, go to CHECK.
- **CHECK**: busy=1.
  - D==0: Q<=all ones, R unchanged (= dividend), div_by_zero<=1, go to DONE.
  - else R>=D: go to SUB.
  - else: go to DONE.
- **SUB**: busy=1. R<=R-D, Q<=Q+1, go to CHECK.
  - R-D never underflows, because SUB is only entered when R>=D.
  - Q cannot wrap: the maximum is 2^WIDTH-1, reached at divisor=1.
- **DONE**: done=1, busy=1 for this one cycle, go to IDLE.
- Result holding: quotient, remainder and div_by_zero hold after DONE until the next accepted start.
- Intermediate values: during CHECK/SUB, quotient and remainder show intermediate values. They are valid only with done=1 or in IDLE after a completed operation.
- Ignored start: start while not in IDLE (including the DONE cycle) is ignored and not queued.
- Unused encodings: unused state values go to IDLE on the next edge with outputs cleared as in reset.
- Results: quotient = floor(dividend/divisor), remainder = dividend mod divisor. Invariant for divisor≠0: Q*divisor + R = dividend.

## Timing
- Edge A is the edge that samples start=1 in IDLE.
- Latency: done is high in the cycle following edge A + (2·Q_final+1) further edges. That is 2·Q_final+2 edges counted including A.
  - divisor=0: 2 edges.
  - dividend<divisor: 2 edges.
- Iteration cost: 2 cycles per quotient unit (CHECK+SUB). Worst case is divisor=1, dividend=2^WIDTH-1: 2^(WIDTH+1) edges.
- Back-to-back: the earliest new acceptance is the edge after DONE (IDLE cycle). The minimum start-to-start spacing is 2·Q+3 cycles.
- done: high exactly one cycle per operation; never high in IDLE, CHECK or SUB.
- Reset: asserting rst_n drives all outputs to reset values asynchronously. The first acceptance is possible on the first edge with rst_n=1.

## Test plan
- 100/7: start one cycle → done 30 edges after A; quotient=14, remainder=2, div_by_zero=0; done width exactly 1 cycle.
- Boundaries:
  - 5/9 → Q=0, R=5, done at 2 edges.
  - 9/9 → Q=1, R=0, done at 4 edges.
  - 0/3 → Q=0, R=0, done at 2 edges.
- 1234/0 → div_by_zero=1, quotient=16'hFFFF, remainder=1234, done at 2 edges. The next operation 10/3 clears the flag and gives Q=3, R=1.
- 1000/1 → Q=1000, R=0, done at 2002 edges. Hold start=1 continuously: a second op starts only at the IDLE edge after DONE. Operand changes while busy have no effect.
- Reset: rst_n low during SUB of 500/2 → all outputs 0 immediately with no done; after release, 17/4 → Q=4, R=1.
- Random: 1000 random pairs with divisor≠0 against the model Q*d+R=n, R<d. Check latency 2Q+2 and busy/done consistency each cycle.
